cp0_timer_unit: RTL and testbench
=================================

// Module: cp0_timer_unit
// PURPOSE
//  Parametrised coprocessor-0 for the MEM stage: SR/Cause/EPC/PrID plus a Count/Compare timer
//  whose match raises an internal interrupt on the top HW line. It arbitrates interrupts and
//  exceptions, drives kernel-entry/ERET control to the pipeline controller, and serves MFC0/MTC0.
// PARAMETERS
//  NUM_HWINT  6             number of HW interrupt lines, 1..6; mapped to IP/IM bits [9+NUM_HWINT:10]
//  HAS_TIMER  1             1: Count(9)/Compare(11) present, match ORed into line NUM_HWINT-1
//  RESET_EPC  32'h0000_3000 EPC value after reset
//  PRID       32'hbaad_face read-only PrID(15) value
// PORTS
//  clk       in  1          clock
//  reset     in  1          synchronous, active-high
//  stall     in  1          MEM stage held this cycle
//  pc        in  32         PC of the instruction currently in MEM
//  bd_flag   in  1          the MEM instruction sits in a branch delay slot
//  exc_code  in  5          pending exception code; 0 = none
//  is_mfc0   in  1          the MEM instruction is MFC0
//  is_mtc0   in  1          the MEM instruction is MTC0
//  is_eret   in  1          the MEM instruction is ERET
//  reg_id    in  5          CP0 register number (rd field)
//  wdata     in  32         MTC0 write data (already forwarded)
//  hw_int    in  NUM_HWINT  external interrupt lines, level sensitive
//  kctrl     out 2          00 none, 01 enter kernel text, 10 ERET
//  epc       out 32         current EPC, [1:0] always 0
//  is_bd     out 1          bd_flag when kctrl==01, else 0
//  rdata     out 32         MFC0 read data
//  timer_irq out 1          sticky timer-match pending flag
// BEHAVIOUR
//  Reset state:
//  - IM = all 1; IE = 1; EXL = 0; IP = 0; ExcCode = 0; BD = 0.
//  - EPC = RESET_EPC; Count = 0; Compare = 0; timer_irq = 0.
//  Register layout:
//  - SR    = {16'b0, IM, 8'b0, EXL, IE}, IM zero-extended to 6 bits.
//  - Cause = {BD, 15'b0, IP, 3'b0, ExcCode, 2'b0}.
//  Combinational:
//  - ip_now = hw_int | (timer_irq << (NUM_HWINT-1)) when HAS_TIMER, else hw_int.
//  - intr = |(IM & ip_now) && IE && !EXL.
//  - excp = (exc_code != 0).
//  - kctrl = stall ? 00 : (intr|excp) ? 01 : is_eret ? 10 : 00. Kernel entry beats ERET.
//  - rdata = is_mfc0 ? {SR | Cause | EPC | PrID | Count | Compare} selected by reg_id
//    (12/13/14/15/9/11) : 0. Any other reg_id reads 0; so do 9/11 when HAS_TIMER=0.
//  - rdata shows pre-update state, zero latency.
//  Sequential, every cycle, including during stall:
//  - IP <= ip_now.
//  - Count <= Count+1, wrapping 0xFFFF_FFFF -> 0.
//  - timer_irq set when the incremented Count equals Compare and Compare != 0.
//  Sequential, only when !stall, in this priority:
//  1. intr|excp: EXL<=1; ExcCode <= intr ? 0 : exc_code (interrupt outranks exception);
//     BD<=bd_flag; EPC <= bd_flag ? pc-4 : pc. A concurrent MTC0/ERET is discarded.
//  2. is_eret: EXL<=0; ExcCode<=0; BD<=0.
//  3. is_mtc0:
//     - SR(12): IM, EXL, IE loaded from wdata.
//     - EPC(14): EPC <= {wdata[31:2], 2'b0}.
//     - Count(9): write beats the increment.
//     - Compare(11): Compare <= wdata and timer_irq <= 0; a clear beats a same-cycle set.
//     - Writes to 13, 15 or unknown IDs are ignored.
//  Reset asserted mid-operation returns every register to reset state on the next edge;
//  kctrl is purely combinational, so no kernel-entry request is held across reset.
// TESTING
//  - Reset, then MFC0 12/13/14/15 -> 0x0000FC01, 0x0, 0x3000, 0xbaadface; kctrl=00.
//  - exc_code=5, pc=0x3010, bd=1 -> kctrl=01, is_bd=1; next cycle EPC=0x300C,
//    Cause=0x80000014, SR.EXL=1.
//  - hw_int[2]=1 with exc_code=4 in the same cycle -> Cause.ExcCode=0 (interrupt wins).
//    Same line while EXL=1 -> kctrl=00.
//  - MTC0 Compare=5, Count=0 -> timer_irq rises after 5 edges; IP[7]=1 -> kctrl=01.
//    MTC0 Compare clears timer_irq.
//  - stall=1 with exc_code=4 -> kctrl=00, EPC and EXL unchanged, Count still increments.
//    Drop stall -> entry taken.
//  - MTC0 Count=0xFFFFFFFF -> Count reads 0 one cycle later.
//    ERET plus exc_code in the same cycle -> kctrl=01, EXL stays 1.

Source files
------------

// File: rtl/cp0_timer_unit.sv
// Coprocessor-0 for the MEM stage: SR/Cause/EPC/PrID, Count/Compare timer,
// interrupt/exception arbitration and kernel-entry/ERET control.
module cp0_timer_unit #(
    parameter int          NUM_HWINT = 6,
    parameter int          HAS_TIMER = 1,
    parameter logic [31:0] RESET_EPC = 32'h0000_3000,
    parameter logic [31:0] PRID      = 32'hbaad_face
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [31:0]          pc,
    input  logic                 bd_flag,
    input  logic [4:0]           exc_code,
    input  logic                 is_mfc0,
    input  logic                 is_mtc0,
    input  logic                 is_eret,
    input  logic [4:0]           reg_id,
    input  logic [31:0]          wdata,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic [1:0]           kctrl,
    output logic [31:0]          epc,
    output logic                 is_bd,
    output logic [31:0]          rdata,
    output logic                 timer_irq
);

    localparam logic [NUM_HWINT-1:0] TOP_LINE =
        NUM_HWINT'(1) << (NUM_HWINT - 1);

    logic [NUM_HWINT-1:0] im;
    logic [NUM_HWINT-1:0] ip;
    logic                 ie;
    logic                 exl;
    logic [4:0]           exc_q;
    logic                 bd_q;
    logic [31:0]          epc_q;
    logic [31:0]          count_q;
    logic [31:0]          compare_q;

    logic [NUM_HWINT-1:0] ip_now;
    logic                 intr;
    logic                 excp;
    logic                 take;
    logic [31:0]          count_inc;
    logic                 timer_hit;
    logic [31:0]          epc_src;
    logic [31:0]          sr_val;
    logic [31:0]          cause_val;
    logic [5:0]           im6;
    logic [5:0]           ip6;

    always_comb begin
        ip_now = hw_int;
        if (HAS_TIMER != 0 && timer_irq)
            ip_now = hw_int | TOP_LINE;
    end

    assign intr      = (|(im & ip_now)) && ie && !exl;
    assign excp      = (exc_code != 5'd0);
    assign take      = intr || excp;
    assign count_inc = count_q + 32'd1;
    assign timer_hit = (HAS_TIMER != 0) && (count_inc == compare_q)
                       && (compare_q != 32'd0);
    assign epc_src   = bd_flag ? (pc - 32'd4) : pc;

    assign im6       = 6'(im);
    assign ip6       = 6'(ip);
    assign sr_val    = {16'b0, im6, 8'b0, exl, ie};
    assign cause_val = {bd_q, 15'b0, ip6, 3'b0, exc_q, 2'b0};

    always_comb begin
        kctrl = 2'b00;
        if (!stall) begin
            if (take)
                kctrl = 2'b01;
            else if (is_eret)
                kctrl = 2'b10;
        end
    end

    assign is_bd = (kctrl == 2'b01) && bd_flag;
    assign epc   = epc_q;

    always_comb begin
        rdata = 32'd0;
        if (is_mfc0) begin
            case (reg_id)
                5'd12: rdata = sr_val;
                5'd13: rdata = cause_val;
                5'd14: rdata = epc_q;
                5'd15: rdata = PRID;
                5'd9:  rdata = (HAS_TIMER != 0) ? count_q : 32'd0;
                5'd11: rdata = (HAS_TIMER != 0) ? compare_q : 32'd0;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '1;
            ie        <= 1'b1;
            exl       <= 1'b0;
            ip        <= '0;
            exc_q     <= 5'd0;
            bd_q      <= 1'b0;
            epc_q     <= {RESET_EPC[31:2], 2'b00};
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            timer_irq <= 1'b0;
        end else begin
            ip <= ip_now;
            if (HAS_TIMER != 0) begin
                count_q <= count_inc;
                if (timer_hit)
                    timer_irq <= 1'b1;
            end
            // Entry discards any concurrent MTC0 or ERET
            if (!stall) begin
                if (take) begin
                    exl   <= 1'b1;
                    exc_q <= intr ? 5'd0 : exc_code;
                    bd_q  <= bd_flag;
                    epc_q <= {epc_src[31:2], 2'b00};
                end else if (is_eret) begin
                    exl   <= 1'b0;
                    exc_q <= 5'd0;
                    bd_q  <= 1'b0;
                end else if (is_mtc0) begin
                    case (reg_id)
                        5'd12: begin
                            im  <= wdata[9+NUM_HWINT:10];
                            exl <= wdata[1];
                            ie  <= wdata[0];
                        end
                        5'd14: epc_q <= {wdata[31:2], 2'b00};
                        5'd9: begin
                            if (HAS_TIMER != 0)
                                count_q <= wdata;
                        end
                        5'd11: begin
                            if (HAS_TIMER != 0) begin
                                compare_q <= wdata;
                                timer_irq <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed bench for cp0_timer_unit: reset, entry/ERET, timer, stall,
// Count wrap and MTC0 side effects.
module tb_cp0_timer_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc;
    logic        bd_flag;
    logic [4:0]  exc_code;
    logic        is_mfc0;
    logic        is_mtc0;
    logic        is_eret;
    logic [4:0]  reg_id;
    logic [31:0] wdata;
    logic [5:0]  hw_int;
    logic [1:0]  kctrl;
    logic [31:0] epc;
    logic        is_bd;
    logic [31:0] rdata;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    cp0_timer_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .bd_flag(bd_flag), .exc_code(exc_code), .is_mfc0(is_mfc0),
        .is_mtc0(is_mtc0), .is_eret(is_eret), .reg_id(reg_id),
        .wdata(wdata), .hw_int(hw_int), .kctrl(kctrl), .epc(epc),
        .is_bd(is_bd), .rdata(rdata), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] r);
        is_mfc0 = 1'b1;
        reg_id  = r;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        is_mtc0 = 1'b1;
        reg_id  = r;
        wdata   = d;
        step();
        is_mtc0 = 1'b0;
    endtask

    task automatic eret();
        is_eret = 1'b1;
        step();
        is_eret = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_FC01) begin
            failures++; $display("FAIL reset_sr got=%h exp=%h", rdata, 32'h0000_FC01);
        end
        rd(5'd13); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL reset_cause got=%h exp=0", rdata);
        end
        rd(5'd14); checks++;
        if (rdata !== 32'h3000 || epc !== 32'h3000) begin
            failures++; $display("FAIL reset_epc got=%h/%h exp=3000", rdata, epc);
        end
        rd(5'd15); checks++;
        if (rdata !== 32'hbaad_face) begin
            failures++; $display("FAIL reset_prid got=%h exp=baadface", rdata);
        end
        checks++;
        if (kctrl !== 2'b00 || timer_irq !== 1'b0) begin
            failures++; $display("FAIL reset_ctl kctrl=%b tirq=%b exp=00/0", kctrl, timer_irq);
        end
    endtask

    task automatic test_exception();
        exc_code = 5'd5; pc = 32'h3010; bd_flag = 1'b1;
        #1; checks++;
        if (kctrl !== 2'b01 || is_bd !== 1'b1) begin
            failures++; $display("FAIL exc_kctrl kctrl=%b bd=%b exp=01/1", kctrl, is_bd);
        end
        step();
        exc_code = 5'd0; bd_flag = 1'b0;
        rd(5'd14); checks++;
        if (rdata !== 32'h300C) begin
            failures++; $display("FAIL exc_epc got=%h exp=300c", rdata);
        end
        rd(5'd13); checks++;
        if (rdata !== 32'h8000_0014) begin
            failures++; $display("FAIL exc_cause got=%h exp=80000014", rdata);
        end
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_FC03) begin
            failures++; $display("FAIL exc_sr got=%h exp=0000fc03", rdata);
        end
        is_eret = 1'b1;
        #1; checks++;
        if (kctrl !== 2'b10) begin
            failures++; $display("FAIL eret_kctrl got=%b exp=10", kctrl);
        end
        step();
        is_eret = 1'b0;
        rd(5'd13); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL eret_cause got=%h exp=0", rdata);
        end
    endtask

    task automatic test_int_priority();
        pc = 32'h3100; hw_int = 6'b000100; exc_code = 5'd4;
        #1; checks++;
        if (kctrl !== 2'b01 || is_bd !== 1'b0) begin
            failures++; $display("FAIL int_kctrl kctrl=%b bd=%b exp=01/0", kctrl, is_bd);
        end
        step();
        exc_code = 5'd0;
        rd(5'd13); checks++;
        if (rdata !== 32'h0000_1000) begin
            failures++; $display("FAIL int_cause got=%h exp=00001000", rdata);
        end
        rd(5'd14); checks++;
        if (rdata !== 32'h3100) begin
            failures++; $display("FAIL int_epc got=%h exp=3100", rdata);
        end
        checks++;
        if (kctrl !== 2'b00) begin
            failures++; $display("FAIL int_exl_mask got=%b exp=00", kctrl);
        end
        hw_int = 6'b0;
        eret();
    endtask

    task automatic test_timer();
        pc = 32'h3200;
        mtc0(5'd9, 32'h100);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (4) step();
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++; $display("FAIL timer_early got=%b exp=0", timer_irq);
        end
        step();
        checks++;
        if (timer_irq !== 1'b1 || kctrl !== 2'b01) begin
            failures++; $display("FAIL timer_fire tirq=%b kctrl=%b exp=1/01", timer_irq, kctrl);
        end
        step();
        rd(5'd13); checks++;
        if (rdata !== 32'h0000_8000) begin
            failures++; $display("FAIL timer_cause got=%h exp=00008000", rdata);
        end
        rd(5'd14); checks++;
        if (rdata !== 32'h3200) begin
            failures++; $display("FAIL timer_epc got=%h exp=3200", rdata);
        end
        mtc0(5'd11, 32'd0);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++; $display("FAIL timer_clear got=%b exp=0", timer_irq);
        end
        eret();
    endtask

    task automatic test_stall();
        mtc0(5'd9, 32'h50);
        stall = 1'b1; exc_code = 5'd4; pc = 32'h4000;
        #1; checks++;
        if (kctrl !== 2'b00) begin
            failures++; $display("FAIL stall_kctrl got=%b exp=00", kctrl);
        end
        step();
        rd(5'd9); checks++;
        if (rdata !== 32'h51) begin
            failures++; $display("FAIL stall_count got=%h exp=51", rdata);
        end
        rd(5'd14); checks++;
        if (rdata !== 32'h3200) begin
            failures++; $display("FAIL stall_epc got=%h exp=3200", rdata);
        end
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_FC01) begin
            failures++; $display("FAIL stall_sr got=%h exp=0000fc01", rdata);
        end
        stall = 1'b0;
        #1; checks++;
        if (kctrl !== 2'b01) begin
            failures++; $display("FAIL unstall_kctrl got=%b exp=01", kctrl);
        end
        step();
        exc_code = 5'd0;
        rd(5'd14); checks++;
        if (rdata !== 32'h4000) begin
            failures++; $display("FAIL unstall_epc got=%h exp=4000", rdata);
        end
        rd(5'd13); checks++;
        if (rdata !== 32'h10) begin
            failures++; $display("FAIL unstall_cause got=%h exp=10", rdata);
        end
        eret();
    endtask

    task automatic test_count_wrap();
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9); checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL wrap_write got=%h exp=ffffffff", rdata);
        end
        step();
        rd(5'd9); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL wrap_zero got=%h exp=0", rdata);
        end
    endtask

    task automatic test_eret_vs_exc();
        is_eret = 1'b1; exc_code = 5'd8; pc = 32'h5000;
        #1; checks++;
        if (kctrl !== 2'b01) begin
            failures++; $display("FAIL eretexc_kctrl got=%b exp=01", kctrl);
        end
        step();
        is_eret = 1'b0; exc_code = 5'd0;
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_FC03) begin
            failures++; $display("FAIL eretexc_sr got=%h exp=0000fc03", rdata);
        end
        rd(5'd13); checks++;
        if (rdata !== 32'h20) begin
            failures++; $display("FAIL eretexc_cause got=%h exp=20", rdata);
        end
        eret();
    endtask

    task automatic test_mtc0_misc();
        mtc0(5'd14, 32'h1234_5677);
        rd(5'd14); checks++;
        if (rdata !== 32'h1234_5674 || epc !== 32'h1234_5674) begin
            failures++; $display("FAIL mtc0_epc got=%h/%h exp=12345674", rdata, epc);
        end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL mtc0_cause_ro got=%h exp=0", rdata);
        end
        mtc0(5'd12, 32'h0000_0400);
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_0400) begin
            failures++; $display("FAIL mtc0_sr got=%h exp=00000400", rdata);
        end
        hw_int = 6'b000001;
        #1; checks++;
        if (kctrl !== 2'b00) begin
            failures++; $display("FAIL ie_mask got=%b exp=00", kctrl);
        end
        mtc0(5'd12, 32'h0000_0401);
        checks++;
        if (kctrl !== 2'b01) begin
            failures++; $display("FAIL ie_unmask got=%b exp=01", kctrl);
        end
        hw_int = 6'b0;
        rd(5'd20); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL rd_unknown got=%h exp=0", rdata);
        end
        is_mfc0 = 1'b0; reg_id = 5'd15;
        #1; checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL rd_idle got=%h exp=0", rdata);
        end
    endtask

    task automatic test_reset_mid();
        exc_code = 5'd3;
        step();
        exc_code = 5'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(5'd12); checks++;
        if (rdata !== 32'h0000_FC01) begin
            failures++; $display("FAIL rst_mid_sr got=%h exp=0000fc01", rdata);
        end
        rd(5'd14); checks++;
        if (rdata !== 32'h3000) begin
            failures++; $display("FAIL rst_mid_epc got=%h exp=3000", rdata);
        end
        rd(5'd13); checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL rst_mid_cause got=%h exp=0", rdata);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc = 32'h0; bd_flag = 1'b0;
        exc_code = 5'd0; is_mfc0 = 1'b0; is_mtc0 = 1'b0;
        is_eret = 1'b0; reg_id = 5'd0; wdata = 32'h0; hw_int = 6'b0;
        test_reset();
        test_exception();
        test_int_priority();
        test_timer();
        test_stall();
        test_count_wrap();
        test_eret_vs_exc();
        test_mtc0_misc();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
